// File: rtl/clk_div_reconfig_ctrl_pkg.sv
// Shared definitions for the clock divider reconfiguration sequencer:
// sequencer states, configuration bus field positions and reset value.
package clk_div_reconfig_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OLD = 3'd1,
    LOAD     = 3'd2,
    SETTLE   = 3'd3,
    WAIT_NEW = 3'd4,
    DONE     = 3'd5
  } state_e;

  localparam int CFG_SEL    = 0;
  localparam int CFG_EN     = 1;
  localparam int CFG_DA_LSB = 2;
  localparam int CFG_DB_LSB = 5;
  localparam int DIV_W      = 3;

  localparam logic [7:0] CFG_RST = 8'h00;

  // Select and both divide factors come from the pending request; the enable
  // bit keeps its current (gated) value.
  function automatic logic [7:0] cfg_load(input logic [7:0] cur, input logic [7:0] pend);
    logic [7:0] r;
    r = cur;
    r[CFG_SEL] = pend[CFG_SEL];
    r[CFG_DA_LSB +: DIV_W] = pend[CFG_DA_LSB +: DIV_W];
    r[CFG_DB_LSB +: DIV_W] = pend[CFG_DB_LSB +: DIV_W];
    return r;
  endfunction

endpackage

// File: rtl/clk_div_reconfig_ctrl_bit_sync.sv
// Multi-flop synchroniser for one asynchronous monitor input.
module clk_div_reconfig_ctrl_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_div_reconfig_ctrl.sv
// Glitch-free reconfiguration sequencer for the dual clock divider/selector.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request; output keeps the last applied config
// WAIT_OLD | output gated, waiting for the old selected clock to be low
// LOAD     | select and divide factors written, enable still 0
// SETTLE   | dividers settle for SETTLE_CYCLES cycles
// WAIT_NEW | waiting for the new selected clock to be low before enabling
// DONE     | one-cycle completion pulse
module clk_div_reconfig_ctrl
  import clk_div_reconfig_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 63,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cfg,
  output logic [7:0] cfg_out,
  input  logic       clk_a_mon,
  input  logic       clk_b_mon,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  input  logic       err_clr
);

  // The wait counter holds the number of wait cycles already elapsed, so the
  // last allowed wait cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cfg_q;
  logic [7:0] pend;
  logic [7:0] tmo_cnt;
  logic [3:0] settle_cnt;
  logic       err_q;
  logic       mon_a_s, mon_b_s, mon_sel;
  logic       accept, wait_exit, tmo_hit;

  clk_div_reconfig_ctrl_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_a_mon),
    .q     (mon_a_s)
  );

  clk_div_reconfig_ctrl_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_b_mon),
    .q     (mon_b_s)
  );

  // Same polarity as the divider mux: select=1 picks clock A.
  assign mon_sel = cfg_q[CFG_SEL] ? mon_a_s : mon_b_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    wait_exit = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = cfg_q[CFG_EN] ? WAIT_OLD : LOAD;
        end
      end
      WAIT_OLD, WAIT_NEW: begin
        if (!mon_sel) begin
          wait_exit = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          wait_exit = 1'b1;
          tmo_hit   = 1'b1;
        end
        if (wait_exit) state_d = (state_q == WAIT_OLD) ? LOAD : DONE;
      end
      LOAD:    state_d = SETTLE;
      SETTLE: begin
        if (settle_cnt <= 4'd1) state_d = pend[CFG_EN] ? WAIT_NEW : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending request capture and the configuration bus register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= CFG_RST;
      cfg_q <= CFG_RST;
    end else begin
      if (accept) begin
        pend          <= req_cfg;
        cfg_q[CFG_EN] <= 1'b0;
      end
      if (state_q == LOAD) cfg_q <= cfg_load(cfg_q, pend);
      if (state_q == WAIT_NEW && wait_exit) cfg_q[CFG_EN] <= 1'b1;
    end
  end

  // Settle down-counter: loaded in LOAD, reaches zero on the edge leaving SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  settle_cnt <= '0;
    else if (state_q == LOAD)    settle_cnt <= SETTLE_INIT;
    else if (state_q == SETTLE)  settle_cnt <= settle_cnt - 4'd1;
  end

  // Wait-state timeout counter: zero on entry, counts wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state_q == WAIT_OLD || state_q == WAIT_NEW) && !wait_exit) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cfg_out     = cfg_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
// Randomized bench for clk_div_reconfig_ctrl. Monitor waveforms are generated
// up front; each request's timeline (gated, loaded, enabled, done) is derived
// from the sequencing rules and the known monitor levels, then every cycle
// of the DUT outputs is compared with that timeline.
module tb_clk_div_reconfig_ctrl;

  localparam int SETTLE_CYCLES = 4;
  localparam int TIMEOUT       = 63;
  localparam int SYNC_STAGES   = 2;
  localparam int MAX_CYC       = 16384;
  localparam int N_TX          = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_cfg = 8'h00;
  logic       clk_a_mon = 1'b0;
  logic       clk_b_mon = 1'b0;
  logic       err_clr = 1'b0;
  logic       req_ready, busy, done, err_timeout;
  logic [7:0] cfg_out;

  clk_div_reconfig_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cfg     (req_cfg),
    .cfg_out     (cfg_out),
    .clk_a_mon   (clk_a_mon),
    .clk_b_mon   (clk_b_mon),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // cyc = index of the clock period that started at the most recent posedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         hist_a  [MAX_CYC];
  bit         hist_b  [MAX_CYC];
  logic [7:0] exp_cfg [MAX_CYC];
  bit         exp_busy[MAX_CYC];
  bit         exp_done[MAX_CYC];
  bit         tmo_at  [MAX_CYC];
  bit         exp_err;
  logic [7:0] cur_cfg;
  int         last_load, last_done;
  int         n_checks = 0;
  int         n_pass = 0;

  // Monitor level for period k is applied shortly after posedge k.
  always @(posedge clk) begin
    #2;
    if (cyc < MAX_CYC) begin
      clk_a_mon = hist_a[cyc];
      clk_b_mon = hist_b[cyc];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, want);
  endtask

  // A waiting state starting in period 'start' leaves on the first period
  // whose synchronised monitor is low, or is forced out in its TIMEOUT-th
  // period. The synchronised level in period k is the level driven in k-SYNC.
  task automatic wait_scan(input int start, input bit sel, output int exit_c, output bit tmo);
    tmo    = 1'b1;
    exit_c = start + TIMEOUT - 1;
    for (int k = start; k < start + TIMEOUT; k++) begin
      if ((sel ? hist_a[k - SYNC_STAGES] : hist_b[k - SYNC_STAGES]) == 1'b0) begin
        exit_c = k;
        tmo    = 1'b0;
        break;
      end
    end
  endtask

  // Build the expected timeline of a request accepted at the end of period pc.
  task automatic plan(input int pc, input logic [7:0] nc);
    int         e0, k, lc, dc, sc;
    bit         tmo;
    logic [7:0] gated_old, gated_new;
    e0        = pc + 1;
    gated_old = cur_cfg & 8'hFD;
    gated_new = nc & 8'hFD;
    if (cur_cfg[1]) begin
      wait_scan(e0, cur_cfg[0], k, tmo);
      if (tmo) tmo_at[k] = 1'b1;
      lc = k + 1;
    end else begin
      lc = e0;
    end
    sc = lc + SETTLE_CYCLES + 1;
    if (nc[1]) begin
      wait_scan(sc, nc[0], k, tmo);
      if (tmo) tmo_at[k] = 1'b1;
      dc = k + 1;
    end else begin
      dc = sc;
    end
    for (int c = e0; c <= dc; c++) begin
      exp_cfg[c]  = (c <= lc) ? gated_old : gated_new;
      exp_busy[c] = 1'b1;
      exp_done[c] = (c == dc);
    end
    exp_cfg[dc] = nc;
    for (int c = dc + 1; c <= dc + 12; c++) begin
      exp_cfg[c]  = nc;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    cur_cfg   = nc;
    last_load = lc;
    last_done = dc;
  endtask

  task automatic check_cycle(input int c);
    chk("cfg_out", 32'(cfg_out), 32'(exp_cfg[c]));
    chk("busy_ready_done", 32'({busy, req_ready, done}),
        32'({exp_busy[c], ~exp_busy[c], exp_done[c]}));
    chk("err_timeout", 32'(err_timeout), 32'(exp_err));
  endtask

  initial begin
    int  pc, vstart, c, tx, lo, hi, p;
    bit  hold;

    // Monitor waveforms: short low/high runs, occasionally a high run long
    // enough to force a wait-state timeout.
    for (int m = 0; m < 2; m++) begin
      p = 0;
      while (p < MAX_CYC) begin
        lo = int'($urandom_range(1, 8));
        hi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(70, 90))
                                         : int'($urandom_range(0, 15));
        for (int i = 0; i < lo + hi && p < MAX_CYC; i++) begin
          if (m == 0) hist_a[p] = (i >= lo);
          else        hist_b[p] = (i >= lo);
          p++;
        end
      end
    end
    for (int i = 0; i < MAX_CYC; i++) begin
      exp_cfg[i]  = 8'h00;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
      tmo_at[i]   = 1'b0;
    end
    cur_cfg   = 8'h00;
    exp_err   = 1'b0;
    last_load = 0;
    last_done = 0;

    repeat (3) @(negedge clk);
    chk("reset_cfg_out", 32'(cfg_out), 32'h00);
    chk("reset_ready_busy_done", 32'({req_ready, busy, done}), 32'b100);
    chk("reset_err", 32'(err_timeout), 32'h0);
    rst_n = 1'b1;

    pc     = cyc + 3;
    vstart = pc;
    tx     = 0;
    while (!(tx >= N_TX && cyc > last_done + 3) && cyc < MAX_CYC - 400) begin
      @(negedge clk);
      c = cyc;
      check_cycle(c);
      if (tx < N_TX && c >= vstart && c <= pc) begin
        req_valid = 1'b1;
        req_cfg   = 8'($urandom);
        if (c == pc) begin
          if (tx == 0) req_cfg = 8'h6B;
          plan(pc, req_cfg);
          tx++;
          hold   = ($urandom_range(0, 2) == 0);
          pc     = hold ? last_done + 1 : last_done + 1 + int'($urandom_range(0, 3));
          vstart = hold ? last_done - 3 : pc;
        end
      end else begin
        req_valid = 1'b0;
        req_cfg   = 8'($urandom);
      end
      err_clr = ($urandom_range(0, 15) == 0);
      exp_err = tmo_at[c] ? 1'b1 : (err_clr ? 1'b0 : exp_err);
    end
    chk("all_requests_issued", 32'(tx), 32'(N_TX));

    // Reset in the middle of SETTLE: output gated at once, no done pulse.
    @(negedge clk);
    c = cyc;
    check_cycle(c);
    err_clr   = 1'b0;
    req_valid = 1'b1;
    req_cfg   = 8'($urandom) | 8'h02;
    plan(c, req_cfg);
    exp_err = tmo_at[c] ? 1'b1 : exp_err;
    while (cyc < last_load + 2) begin
      @(negedge clk);
      c = cyc;
      check_cycle(c);
      req_valid = 1'b0;
      exp_err = tmo_at[c] ? 1'b1 : exp_err;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cfg_out", 32'(cfg_out), 32'h00);
    chk("midreset_ready_busy_done", 32'({req_ready, busy, done}), 32'b100);
    chk("midreset_err", 32'(err_timeout), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("inreset_done", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("postreset_cfg_out", 32'(cfg_out), 32'h00);
      chk("postreset_ready_busy_done", 32'({req_ready, busy, done}), 32'b100);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
